// File: rtl/conv_sched.sv
// Row-job scheduler: hands output rows of each timestep to free SPE workers round-robin.
// Optional no-progress watchdog is compiled in with `define SCHED_WDOG_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for the first load_done after reset
// S_ISSUE  | offering rows of the current timestep to free SPEs
// S_DRAIN  | all rows handed out, waiting for every SPE to report done
// S_TSDONE | one-cycle ts_done pulse, then next timestep or finish
// S_FINISH | layer complete, all_done held until the next load_done

module conv_sched #(
    parameter int NUM_PE      = 5,
    parameter int NUM_ROWS    = 21,
    parameter int NUM_TS      = 2,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_done,
    output logic              job_valid,
    input  logic              job_ready,
    output logic [2:0]        job_pe,
    output logic [4:0]        job_row,
    output logic [1:0]        job_ts,
    input  logic [NUM_PE-1:0] pe_done,
    output logic              ts_done,
    output logic              all_done,
    output logic [NUM_PE-1:0] busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_TSDONE,
        S_FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        row, row_nxt;
    logic [1:0]        ts, ts_nxt;
    logic [NUM_PE-1:0] busy_nxt;
    logic [2:0]        rr, rr_nxt;
    logic              hold, hold_nxt;
    logic [2:0]        hold_pe, hold_pe_nxt;
    logic              err_nxt;

    logic              free_any;
    logic [2:0]        free_pe;
    logic [3:0]        scan_idx;
    logic              xfer;
    logic              wdog_trip;

    // First free SPE at or after the round-robin pointer.
    always_comb begin
        free_any = 1'b0;
        free_pe  = rr;
        scan_idx = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            scan_idx = {1'b0, rr} + 4'(k);
            if (scan_idx >= 4'(NUM_PE)) begin
                scan_idx = scan_idx - 4'(NUM_PE);
            end
            if (!free_any && !busy[scan_idx[2:0]]) begin
                free_any = 1'b1;
                free_pe  = scan_idx[2:0];
            end
        end
    end

    // A stalled offer keeps its target even if an earlier SPE frees up meanwhile.
    always_comb begin
        job_valid = 1'b0;
        job_pe    = free_pe;
        ts_done   = 1'b0;
        all_done  = 1'b0;
        if (hold) begin
            job_pe = hold_pe;
        end
        case (state)
            S_ISSUE:  job_valid = hold || (free_any && (row < 5'(NUM_ROWS)));
            S_TSDONE: ts_done   = 1'b1;
            S_FINISH: all_done  = 1'b1;
            default:  ;
        endcase
    end

    assign job_row = row;
    assign job_ts  = ts;
    assign xfer    = job_valid & job_ready;

`ifdef SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_armed;
    logic              progress;

    assign wdog_armed = (state == S_ISSUE) || (state == S_DRAIN);
    assign progress   = xfer | (|pe_done);
    assign wdog_trip  = wdog_armed && !progress && (wdog_cnt <= WDOG_W'(1));

    // Down-counter: value 1 marks the last idle cycle before the limit.
    always_ff @(posedge clk) begin
        if (reset || !wdog_armed || progress) begin
            wdog_cnt <= WDOG_W'(WDOG_CYCLES - 1);
        end else if (wdog_cnt != '0) begin
            wdog_cnt <= wdog_cnt - WDOG_W'(1);
        end
    end
`else
    assign wdog_trip = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        ts_nxt      = ts;
        rr_nxt      = rr;
        hold_nxt    = hold;
        hold_pe_nxt = hold_pe;
        busy_nxt    = busy & ~pe_done;
        err_nxt     = err | (|(pe_done & ~busy));

        if (xfer) begin
            busy_nxt[job_pe] = 1'b1;
            row_nxt          = row + 5'd1;
            rr_nxt           = (job_pe == 3'(NUM_PE - 1)) ? 3'd0 : job_pe + 3'd1;
            hold_nxt         = 1'b0;
        end else if (job_valid) begin
            hold_nxt    = 1'b1;
            hold_pe_nxt = job_pe;
        end

        case (state)
            S_IDLE, S_FINISH: begin
                if (load_done) begin
                    state_nxt = S_ISSUE;
                    row_nxt   = '0;
                    ts_nxt    = 2'd1;
                    busy_nxt  = '0;
                end
            end
            S_ISSUE: begin
                if (load_done) err_nxt = 1'b1;
                if (xfer && (row == 5'(NUM_ROWS - 1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (load_done) err_nxt = 1'b1;
                if (busy_nxt == '0) begin
                    state_nxt = S_TSDONE;
                end
            end
            S_TSDONE: begin
                if (load_done) err_nxt = 1'b1;
                if (ts < 2'(NUM_TS)) begin
                    state_nxt = S_ISSUE;
                    ts_nxt    = ts + 2'd1;
                    row_nxt   = '0;
                end else begin
                    state_nxt = S_FINISH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (wdog_trip) begin
            state_nxt = S_FINISH;
            busy_nxt  = '0;
            hold_nxt  = 1'b0;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            row     <= '0;
            ts      <= 2'd1;
            busy    <= '0;
            rr      <= '0;
            hold    <= 1'b0;
            hold_pe <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            ts      <= ts_nxt;
            busy    <= busy_nxt;
            rr      <= rr_nxt;
            hold    <= hold_nxt;
            hold_pe <= hold_pe_nxt;
            err     <= err_nxt;
        end
    end

endmodule
